sfx_arbiter: RTL and testbench
==============================

Name: sfx_arbiter

Overview:
Shares the single board buzzer between three sound-effect requesters: jump, game start, and game over/collision. Each request plays one prioritised, fixed-length square-wave tone. The block sits beside game_logic in the 100 MHz domain. It takes debounced button and gamemode-derived event levels and drives the buzzer pin, and it replaces ad-hoc buzzer driving.

Parameters:
TONE0_DIV, 25000, half-period in clk cycles for requester 0 (jump), 2 kHz at 100 MHz
TONE1_DIV, 50000, half-period for requester 1 (start)
TONE2_DIV, 100000, half-period for requester 2 (game over)
DUR0, 5000000, tone length in clk cycles for requester 0 (50 ms)
DUR1, 20000000, tone length for requester 1
DUR2, 50000000, tone length for requester 2
GAP_CYC, 1000000, forced silence after every tone, in clk cycles
Counter widths are sized from the largest parameter; all parameters are >= 2.

Ports:
clk  input  1  system clock (100 MHz)
rst  input  1  asynchronous, active-high reset
enable  input  1  sound enable; 0 mutes the block and flushes pending requests
req  input  3  event levels; a rising edge on req[k] requests sound k
buzzer  output  1  square-wave drive to the buzzer
busy  output  1  high while state is PLAY or GAP
grant  output  3  one-hot index of the tone playing; 0 outside PLAY
done  output  1  one-cycle pulse when a tone completes its full duration

Behaviour:
- Reset (async, rst=1): state=IDLE, pending=0, req_q=0, all counters 0, buzzer=0, busy=0, grant=0, done=0.
- Edge detect: req_q <= req every cycle. rise[k] = req[k] & ~req_q[k], set into pending[k].
  - Multiple rises of one line while it is pending coalesce into a single request.
  - If a rise and a clear of the same pending bit happen in the same cycle, set wins.
- Priority is fixed: 2 > 1 > 0.
- States: IDLE, PLAY, GAP.
- IDLE, pending != 0: grant <= one-hot of highest pending k; pending[k] cleared; dur_cnt <= DURk-1; div_cnt <= TONEk_DIV-1; buzzer <= 0; state <= PLAY.
  - Latency: req[k] rises in cycle 0 -> pending visible in cycle 1 -> PLAY with grant valid from cycle 2.
- PLAY, per cycle:
  - div_cnt==0: toggle buzzer, reload TONEk_DIV-1. Otherwise decrement. The first toggle occurs TONEk_DIV cycles after PLAY entry.
  - dur_cnt==0: done=1 for one cycle, buzzer<=0, grant<=0, gap_cnt<=GAP_CYC-1, state<=GAP. Otherwise decrement.
  - PLAY lasts exactly DURk cycles.
- Preemption: in PLAY, if pending holds a bit of strictly higher priority than the current grant, the current tone is aborted next cycle (no done, not re-queued) and the block goes to GAP. Equal or lower priority requests stay pending. A fresh rise on the currently playing line sets its pending bit, so the tone replays after GAP.
- GAP: buzzer=0, grant=0. Decrement gap_cnt; at 0 go to IDLE. Pending keeps accumulating during GAP.
- enable=0 (synchronous, any state): next cycle state=IDLE, pending=0, buzzer=0, grant=0, done=0. Rises are ignored while enable=0, but req_q still tracks req, so a level held through re-enable does not trigger.
- The state encoding is illegal-state safe: the default branch returns to IDLE with all outputs cleared.
- rst asserted mid-tone: outputs go to 0 immediately, with no glitch pulse on done.

Test Plan:
All scenarios use TONE0/1/2_DIV=4/3/2, DUR0/1/2=20/30/40, GAP_CYC=5, enable=1 unless stated.
- Single jump: req[0] rises at cycle 0 -> grant=001 and busy from cycle 2; buzzer toggles every 4 cycles starting cycle 6; done pulses at cycle 21; busy falls after 5 GAP cycles, in cycle 27.
- Simultaneous req[0] and req[2] rises -> grant=100 for 40 cycles, then GAP of 5, then grant=001 for 20 cycles, with done pulsing twice.
- Preempt: req[2] rises 10 cycles into a req[0] tone -> jump aborts with no done, GAP of 5, then grant=100 plays 40 cycles; the jump does not replay.
- Coalesce: req[0] pulses three times while a req[1] tone plays -> exactly one jump tone follows; req[1] rising during its own tone -> one replay after GAP.
- enable drops mid-tone -> buzzer=0, grant=0, busy=0 next cycle and pending cleared; req held high across re-enable produces no tone.
- rst pulse mid-PLAY -> all outputs 0 asynchronously; after release a new rise is serviced with the normal 2-cycle latency.

Source files
------------

// File: rtl/sfx_arbiter_if.sv
// sfx_if: sound-enable and request levels in, buzzer drive and tone status out.
interface sfx_if;
    logic       enable;
    logic [2:0] req;
    logic       buzzer;
    logic       busy;
    logic [2:0] grant;
    logic       done;
    modport master (output enable, req, input buzzer, busy, grant, done);
    modport slave (input enable, req, output buzzer, busy, grant, done);
endinterface

// File: rtl/sfx_arbiter.sv
// sfx_arbiter: shares one buzzer between three prioritised one-shot square-wave tones,
// with a forced silent gap after every tone.
module sfx_arbiter #(
    parameter int TONE0_DIV = 25000,
    parameter int TONE1_DIV = 50000,
    parameter int TONE2_DIV = 100000,
    parameter int DUR0      = 5000000,
    parameter int DUR1      = 20000000,
    parameter int DUR2      = 50000000,
    parameter int GAP_CYC   = 1000000
) (
    input logic  clk,
    input logic  rst,
    sfx_if.slave sfx
);
    localparam int M_T = TONE0_DIV > TONE1_DIV ? (TONE0_DIV > TONE2_DIV ? TONE0_DIV : TONE2_DIV)
                                               : (TONE1_DIV > TONE2_DIV ? TONE1_DIV : TONE2_DIV);
    localparam int M_D = DUR0 > DUR1 ? (DUR0 > DUR2 ? DUR0 : DUR2) : (DUR1 > DUR2 ? DUR1 : DUR2);
    localparam int M_A = M_T > M_D ? M_T : M_D;
    localparam int MAX_P = M_A > GAP_CYC ? M_A : GAP_CYC;
    localparam int W = $clog2(MAX_P + 1);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t         state_q, state_d;
    logic [2:0]     req_q, pending_q, pending_d, grant_q, grant_d;
    logic [2:0]     rise, pick;
    logic [W-1:0]   div_q, div_d, dur_q, dur_d, gap_q, gap_d;
    logic [W-1:0]   cur_div;
    logic           buzz_q, buzz_d, preempt;

    always_comb begin
        rise    = sfx.enable ? (sfx.req & ~req_q) : 3'b000;
        pick    = pending_q[2] ? 3'b100 : pending_q[1] ? 3'b010 : pending_q[0] ? 3'b001 : 3'b000;
        preempt = (grant_q[0] & |pending_q[2:1]) | (grant_q[1] & pending_q[2]);
        cur_div = grant_q[2] ? W'(TONE2_DIV - 1) : grant_q[1] ? W'(TONE1_DIV - 1) : W'(TONE0_DIV - 1);
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | rise;
        grant_d   = grant_q;
        div_d     = div_q;
        dur_d     = dur_q;
        gap_d     = gap_q;
        buzz_d    = buzz_q;
        case (state_q)
            IDLE: if (|pending_q) begin
                state_d   = PLAY;
                grant_d   = pick;
                pending_d = (pending_q & ~pick) | rise;
                dur_d     = pick[2] ? W'(DUR2 - 1) : pick[1] ? W'(DUR1 - 1) : W'(DUR0 - 1);
                div_d     = pick[2] ? W'(TONE2_DIV - 1) : pick[1] ? W'(TONE1_DIV - 1) : W'(TONE0_DIV - 1);
                buzz_d    = 1'b0;
            end
            PLAY: if (dur_q == '0 || preempt) begin
                state_d = GAP;
                grant_d = 3'b000;
                buzz_d  = 1'b0;
                gap_d   = W'(GAP_CYC - 1);
            end else begin
                dur_d  = dur_q - 1'b1;
                div_d  = div_q == '0 ? cur_div : div_q - 1'b1;
                buzz_d = div_q == '0 ? ~buzz_q : buzz_q;
            end
            GAP: begin
                grant_d = 3'b000;
                buzz_d  = 1'b0;
                state_d = gap_q == '0 ? IDLE : GAP;
                gap_d   = gap_q == '0 ? gap_q : gap_q - 1'b1;
            end
            default: begin
                state_d   = IDLE;
                pending_d = 3'b000;
                grant_d   = 3'b000;
                buzz_d    = 1'b0;
                div_d     = '0;
                dur_d     = '0;
                gap_d     = '0;
            end
        endcase
        if (!sfx.enable) begin
            state_d   = IDLE;
            pending_d = 3'b000;
            grant_d   = 3'b000;
            buzz_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= 3'b000;
            pending_q <= 3'b000;
            grant_q   <= 3'b000;
            div_q     <= '0;
            dur_q     <= '0;
            gap_q     <= '0;
            buzz_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= sfx.req;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            div_q     <= div_d;
            dur_q     <= dur_d;
            gap_q     <= gap_d;
            buzz_q    <= buzz_d;
        end
    end

    // done is decoded from registered state, so an async reset cannot glitch it
    assign sfx.done   = sfx.enable && state_q == PLAY && dur_q == '0;
    assign sfx.busy   = state_q == PLAY || state_q == GAP;
    assign sfx.grant  = grant_q;
    assign sfx.buzzer = buzz_q;
endmodule

// File: tb/tb_sfx_arbiter.sv
// tb_sfx_arbiter: directed cycle-by-cycle checks of tone priority, timing, preemption,
// coalescing, enable muting and async reset.
module tb_sfx_arbiter;
    logic clk = 1'b0;
    logic rst;
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int base = 0;

    sfx_if sfx ();

    sfx_arbiter #(
        .TONE0_DIV(4), .TONE1_DIV(3), .TONE2_DIV(2),
        .DUR0(20), .DUR1(30), .DUR2(40), .GAP_CYC(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sfx(sfx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (sfx.done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        rst = 1'b1;
        sfx.enable = 1'b1;
        sfx.req = 3'b000;
        at(2);
        chk("rst_buzzer", 32'(sfx.buzzer), 32'd0);
        chk("rst_busy", 32'(sfx.busy), 32'd0);
        chk("rst_grant", 32'(sfx.grant), 32'd0);
        chk("rst_done", 32'(sfx.done), 32'd0);
        rst = 1'b0;
        at(4);

        // single jump
        cyc = 0; base = done_cnt;
        sfx.req = 3'b001;
        chk("t1_busy_c0", 32'(sfx.busy), 32'd0);
        at(1);
        chk("t1_grant_c1", 32'(sfx.grant), 32'd0);
        at(2);
        chk("t1_grant_c2", 32'(sfx.grant), 32'b001);
        chk("t1_busy_c2", 32'(sfx.busy), 32'd1);
        chk("t1_buz_c2", 32'(sfx.buzzer), 32'd0);
        sfx.req = 3'b000;
        at(5);
        chk("t1_buz_c5", 32'(sfx.buzzer), 32'd0);
        at(6);
        chk("t1_buz_c6", 32'(sfx.buzzer), 32'd1);
        at(9);
        chk("t1_buz_c9", 32'(sfx.buzzer), 32'd1);
        at(10);
        chk("t1_buz_c10", 32'(sfx.buzzer), 32'd0);
        at(20);
        chk("t1_done_c20", 32'(sfx.done), 32'd0);
        at(21);
        chk("t1_done_c21", 32'(sfx.done), 32'd1);
        chk("t1_grant_c21", 32'(sfx.grant), 32'b001);
        at(22);
        chk("t1_done_c22", 32'(sfx.done), 32'd0);
        chk("t1_grant_c22", 32'(sfx.grant), 32'd0);
        chk("t1_busy_c22", 32'(sfx.busy), 32'd1);
        at(26);
        chk("t1_busy_c26", 32'(sfx.busy), 32'd1);
        at(27);
        chk("t1_busy_c27", 32'(sfx.busy), 32'd0);
        chk("t1_ndone", 32'(done_cnt - base), 32'd1);

        // simultaneous jump and game over
        cyc = 0; base = done_cnt;
        sfx.req = 3'b101;
        at(2);
        chk("t2_grant_c2", 32'(sfx.grant), 32'b100);
        sfx.req = 3'b000;
        at(41);
        chk("t2_done_c41", 32'(sfx.done), 32'd1);
        chk("t2_grant_c41", 32'(sfx.grant), 32'b100);
        at(42);
        chk("t2_grant_c42", 32'(sfx.grant), 32'd0);
        chk("t2_busy_c42", 32'(sfx.busy), 32'd1);
        at(47);
        chk("t2_busy_c47", 32'(sfx.busy), 32'd0);
        at(48);
        chk("t2_grant_c48", 32'(sfx.grant), 32'b001);
        at(67);
        chk("t2_done_c67", 32'(sfx.done), 32'd1);
        at(68);
        chk("t2_grant_c68", 32'(sfx.grant), 32'd0);
        at(75);
        chk("t2_busy_c75", 32'(sfx.busy), 32'd0);
        chk("t2_ndone", 32'(done_cnt - base), 32'd2);

        // game over preempts jump
        cyc = 0; base = done_cnt;
        sfx.req = 3'b001;
        at(2);
        chk("t3_grant_c2", 32'(sfx.grant), 32'b001);
        sfx.req = 3'b000;
        at(12);
        sfx.req = 3'b100;
        at(13);
        chk("t3_grant_c13", 32'(sfx.grant), 32'b001);
        at(14);
        chk("t3_grant_c14", 32'(sfx.grant), 32'd0);
        chk("t3_busy_c14", 32'(sfx.busy), 32'd1);
        chk("t3_ndone_abort", 32'(done_cnt - base), 32'd0);
        at(19);
        chk("t3_busy_c19", 32'(sfx.busy), 32'd0);
        at(20);
        chk("t3_grant_c20", 32'(sfx.grant), 32'b100);
        sfx.req = 3'b000;
        at(59);
        chk("t3_done_c59", 32'(sfx.done), 32'd1);
        at(65);
        chk("t3_busy_c65", 32'(sfx.busy), 32'd0);
        at(70);
        chk("t3_busy_c70", 32'(sfx.busy), 32'd0);
        chk("t3_grant_c70", 32'(sfx.grant), 32'd0);
        chk("t3_ndone", 32'(done_cnt - base), 32'd1);

        // coalesced jump pulses and self replay of start
        cyc = 0; base = done_cnt;
        sfx.req = 3'b010;
        at(2);
        chk("t4_grant_c2", 32'(sfx.grant), 32'b010);
        sfx.req = 3'b000;
        at(4);  sfx.req = 3'b001;
        at(5);  sfx.req = 3'b000;
        at(7);  sfx.req = 3'b001;
        at(8);  sfx.req = 3'b000;
        at(10); sfx.req = 3'b001;
        at(11); sfx.req = 3'b000;
        at(13); sfx.req = 3'b010;
        at(14); sfx.req = 3'b000;
        at(20);
        chk("t4_grant_c20", 32'(sfx.grant), 32'b010);
        at(31);
        chk("t4_done_c31", 32'(sfx.done), 32'd1);
        chk("t4_grant_c31", 32'(sfx.grant), 32'b010);
        at(37);
        chk("t4_busy_c37", 32'(sfx.busy), 32'd0);
        at(38);
        chk("t4_grant_c38", 32'(sfx.grant), 32'b010);
        at(73);
        chk("t4_busy_c73", 32'(sfx.busy), 32'd0);
        at(74);
        chk("t4_grant_c74", 32'(sfx.grant), 32'b001);
        at(93);
        chk("t4_done_c93", 32'(sfx.done), 32'd1);
        at(99);
        chk("t4_busy_c99", 32'(sfx.busy), 32'd0);
        at(110);
        chk("t4_busy_c110", 32'(sfx.busy), 32'd0);
        chk("t4_ndone", 32'(done_cnt - base), 32'd3);

        // enable drop mid-tone with a pending jump, levels held across re-enable
        cyc = 0; base = done_cnt;
        sfx.req = 3'b100;
        at(2);
        chk("t5_grant_c2", 32'(sfx.grant), 32'b100);
        at(4);
        sfx.req = 3'b101;
        at(8);
        chk("t5_buz_c8", 32'(sfx.buzzer), 32'd1);
        sfx.enable = 1'b0;
        at(9);
        chk("t5_buz_c9", 32'(sfx.buzzer), 32'd0);
        chk("t5_grant_c9", 32'(sfx.grant), 32'd0);
        chk("t5_busy_c9", 32'(sfx.busy), 32'd0);
        at(10);
        sfx.enable = 1'b1;
        at(20);
        chk("t5_busy_c20", 32'(sfx.busy), 32'd0);
        chk("t5_grant_c20", 32'(sfx.grant), 32'd0);
        sfx.req = 3'b000;
        at(22);
        chk("t5_busy_c22", 32'(sfx.busy), 32'd0);
        chk("t5_ndone", 32'(done_cnt - base), 32'd0);

        // async reset mid-tone, then normal service
        cyc = 0; base = done_cnt;
        sfx.req = 3'b010;
        at(2);
        chk("t6_grant_c2", 32'(sfx.grant), 32'b010);
        at(5);
        chk("t6_buz_c5", 32'(sfx.buzzer), 32'd1);
        rst = 1'b1;
        sfx.req = 3'b000;
        #1;
        chk("t6_rst_grant", 32'(sfx.grant), 32'd0);
        chk("t6_rst_busy", 32'(sfx.busy), 32'd0);
        chk("t6_rst_buz", 32'(sfx.buzzer), 32'd0);
        chk("t6_rst_done", 32'(sfx.done), 32'd0);
        at(6);
        rst = 1'b0;
        at(7);
        cyc = 0;
        sfx.req = 3'b010;
        at(1);
        chk("t6_grant_r1", 32'(sfx.grant), 32'd0);
        at(2);
        chk("t6_grant_r2", 32'(sfx.grant), 32'b010);
        chk("t6_busy_r2", 32'(sfx.busy), 32'd1);
        chk("t6_ndone", 32'(done_cnt - base), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
